// File: rtl/btn_cond.sv
// btn_cond: four-channel push-button conditioner.
// Each channel synchronises its raw pin, debounces it, and emits
// single-cycle press/release pulses plus an optional auto-repeat press train.
module btn_cond #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 4800000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_in,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST   = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  logic [3:0] s1_q;
  logic [3:0] s2_q;

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 4'b0000;
      s2_q <= 4'b0000;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             level_q, level_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    state_e           state_q, state_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             accept_s;
    logic             rise_s;
    logic             fall_s;

    // The level flips on the cycle the disagreement has lasted long enough.
    assign accept_s = (s2_q[g] != level_q) && (db_cnt_q == DB_LAST);
    assign rise_s   = accept_s && !level_q;
    assign fall_s   = accept_s && level_q;

    // Debounce: count consecutive cycles where the synchronised pin disagrees.
    always_comb begin
      db_cnt_d = {DB_W{1'b0}};
      level_d  = level_q;
      if (s2_q[g] == level_q) begin
        db_cnt_d = {DB_W{1'b0}};
      end else if (accept_s) begin
        level_d  = ~level_q;
        db_cnt_d = {DB_W{1'b0}};
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    // Repeat engine: next state, repeat counter and pulse generation.
    // A fall is checked first so a release always wins over a coincident repeat.
    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise_s) begin
            press_d   = 1'b1;
            rpt_cnt_d = {RPT_W{1'b0}};
            state_d   = REPEAT_EN ? ST_DELAY : ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (fall_s) begin
            release_d = 1'b1;
            rpt_cnt_d = {RPT_W{1'b0}};
            state_d   = ST_IDLE;
          end else if (rpt_cnt_q == DELAY_LAST) begin
            press_d   = 1'b1;
            rpt_cnt_d = {RPT_W{1'b0}};
            state_d   = ST_REPEAT;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (fall_s) begin
            release_d = 1'b1;
            rpt_cnt_d = {RPT_W{1'b0}};
            state_d   = ST_IDLE;
          end else if (rpt_cnt_q == PER_LAST) begin
            press_d   = 1'b1;
            rpt_cnt_d = {RPT_W{1'b0}};
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end
        ST_HOLD: begin
          if (fall_s) begin
            release_d = 1'b1;
            rpt_cnt_d = {RPT_W{1'b0}};
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          rpt_cnt_d = {RPT_W{1'b0}};
        end
      endcase
    end

    // Channel state registers; outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q  <= {DB_W{1'b0}};
        level_q   <= 1'b0;
        rpt_cnt_q <= {RPT_W{1'b0}};
        state_q   <= ST_IDLE;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        rpt_cnt_q <= rpt_cnt_d;
        state_q   <= state_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
  end

endmodule

// File: tb/tb_btn_cond.sv
// Self-checking bench for btn_cond: directed scenarios plus random pin
// activity, all compared cycle by cycle with a sliding-window reference model.
module tb_btn_cond;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  // Reference model state: pin samples per edge, accepted level, press time.
  logic [3:0] hist[$];
  logic [3:0] m_lvl;
  int         p_start[4];
  logic [3:0] seen_ch2;

  btn_cond #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_EN(1'b1),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%b exp=%b", tag, edge_n, got, exp);
    end
  endtask

  // Reset leaves the synchroniser holding zeros, i.e. zero samples in history.
  task automatic model_reset();
    m_lvl = 4'b0000;
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(4'b0000);
    for (int c = 0; c < 4; c++) p_start[c] = 0;
  endtask

  // A level flips when the last D synchronised samples (pins seen 2..D+1
  // edges ago) all differ from it; repeats follow at +RD then every +RP.
  task automatic model_step(output logic [3:0] ep, output logic [3:0] er);
    logic [3:0] s;
    int         d;
    bit         all_diff;
    edge_n++;
    hist.push_back(btn_in);
    if (hist.size() > D + 4) void'(hist.pop_front());
    ep = 4'b0000;
    er = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      all_diff = 1'b1;
      for (int k = 0; k < D; k++) begin
        s = hist[hist.size() - 3 - k];
        if (s[c] == m_lvl[c]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_lvl[c] = ~m_lvl[c];
        if (m_lvl[c]) begin
          ep[c]      = 1'b1;
          p_start[c] = edge_n;
        end else begin
          er[c] = 1'b1;
        end
      end else if (m_lvl[c]) begin
        d = edge_n - p_start[c];
        if (d >= RD && ((d - RD) % RP) == 0) ep[c] = 1'b1;
      end
    end
  endtask

  // One clock: drive pins at the falling edge, check just after the rising edge.
  task automatic step(input logic [3:0] v);
    logic [3:0] ep, er;
    @(negedge clk);
    btn_in = v;
    @(posedge clk);
    #1;
    model_step(ep, er);
    check_eq("level", btn_level, m_lvl);
    check_eq("press", btn_press, ep);
    check_eq("release", btn_release, er);
    seen_ch2 = seen_ch2 | {1'b0, btn_level[2] | btn_press[2] | btn_release[2], 2'b00};
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_level"}, btn_level, 4'b0000);
    check_eq({tag, "_press"}, btn_press, 4'b0000);
    check_eq({tag, "_release"}, btn_release, 4'b0000);
  endtask

  initial begin
    int         run[4];
    logic [3:0] cur;
    seen_ch2 = 4'b0000;
    btn_in   = 4'b0000;
    rst_n    = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();

    // Clean press on up: pulse on edge k+5, one cycle wide.
    for (int i = 0; i <= 5; i++) step(4'b0001);
    check_eq("clean_press_k5", btn_press, 4'b0001);
    step(4'b0001);
    check_eq("clean_press_width", btn_press, 4'b0000);
    for (int i = 0; i < 3; i++) step(4'b0001);
    for (int i = 0; i < 8; i++) step(4'b0000);

    // Bounce rejection on right.
    seen_ch2 = 4'b0000;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) step(4'b0100);
      step(4'b0000);
    end
    for (int i = 0; i < 8; i++) step(4'b0000);
    check_eq("bounce_quiet", seen_ch2, 4'b0000);

    // Auto-repeat on down, then release.
    for (int i = 0; i < 45; i++) step(4'b1000);
    for (int i = 0; i < 12; i++) step(4'b0000);

    // Release landing on the P+15 repeat edge (P at step 5, fall at step 20).
    for (int i = 0; i <= 20; i++) begin
      step((i < 15) ? 4'b0001 : 4'b0000);
      if (i == 20) begin
        check_eq("collide_release", btn_release, 4'b0001);
        check_eq("collide_press", btn_press, 4'b0000);
      end
    end
    for (int i = 0; i < 6; i++) step(4'b0000);

    // Simultaneous up and down.
    for (int i = 0; i < 25; i++) begin
      step(4'b1001);
      if (i == 5) check_eq("simul_press", btn_press, 4'b1001);
      if (i == 15) check_eq("simul_repeat", btn_press, 4'b1001);
    end
    for (int i = 0; i < 8; i++) step(4'b0000);

    // Reset while left is held in the repeat phase.
    for (int i = 0; i < 25; i++) step(4'b0010);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    check_all_zero("midreset_hold");
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i <= 5; i++) begin
      step(4'b0010);
      if (i < 5) check_eq("postreset_no_rel", btn_release, 4'b0000);
    end
    check_eq("postreset_press", btn_press, 4'b0010);
    for (int i = 0; i < 8; i++) step(4'b0000);

    // Random pin activity: mix of short bounces and long holds per channel.
    cur = 4'b0000;
    for (int c = 0; c < 4; c++) run[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (run[c] == 0) begin
          cur[c] = ~cur[c];
          run[c] = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 40));
        end
        run[c] = run[c] - 1;
      end
      step(cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
